// File: rtl/mmu_pkg.sv
// Shared types and default memory map for the core-to-target region router.
package mmu_pkg;

  localparam int unsigned MEM_W_DEF = 32;
  localparam int unsigned N_TGT_DEF = 3;
  localparam int unsigned ID_W      = $clog2(N_TGT_DEF + 1);

  typedef logic [ID_W-1:0] tgt_id_t;

  localparam tgt_id_t ERR_ID = tgt_id_t'(N_TGT_DEF);

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] limit;
  } region_t;

  localparam region_t GPIO_REGION    = '{base: 32'h0000_0101, limit: 32'h0000_010A};
  localparam region_t TIMER_REGION   = '{base: 32'h0000_010B, limit: 32'h0000_010B};
  localparam region_t STORAGE_REGION = '{base: 32'h0000_1000, limit: 32'hFFFF_FFFF};

  // Target i occupies bits [i*32 +: 32]; GPIO is target 0.
  localparam logic [N_TGT_DEF*32-1:0] DEF_REGION_BASE =
    {STORAGE_REGION.base, TIMER_REGION.base, GPIO_REGION.base};
  localparam logic [N_TGT_DEF*32-1:0] DEF_REGION_LIMIT =
    {STORAGE_REGION.limit, TIMER_REGION.limit, GPIO_REGION.limit};

  function automatic logic in_region(input region_t r, input logic [31:0] addr);
    return (addr >= r.base) && (addr <= r.limit);
  endfunction

endpackage

// File: rtl/router_id_fifo.sv
// In-order FIFO of outstanding transaction tags (target id plus write flag).
module router_id_fifo
  import mmu_pkg::*;
#(
  parameter int unsigned W     = $bits(tgt_id_t) + 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/mem_region_router.sv
// Routes core data-port requests to address-mapped targets and returns
// responses in issue order; unmapped addresses get an error response.
module mem_region_router
  import mmu_pkg::*;
#(
  parameter int unsigned MEM_W   = MEM_W_DEF,
  parameter int unsigned N_TGT   = N_TGT_DEF,
  parameter int unsigned MAX_OUT = 4,
  parameter logic [N_TGT*32-1:0] REGION_BASE  = DEF_REGION_BASE,
  parameter logic [N_TGT*32-1:0] REGION_LIMIT = DEF_REGION_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vproc_mem_req_o,
  output logic                   vproc_mem_gnt_i,
  input  logic [31:0]            vproc_mem_addr_o,
  input  logic                   vproc_mem_we_o,
  input  logic [MEM_W/8-1:0]     vproc_mem_be_o,
  input  logic [MEM_W-1:0]       vproc_mem_wdata_o,
  output logic                   vproc_mem_rvalid_i,
  output logic                   vproc_mem_err_i,
  output logic [MEM_W-1:0]       vproc_mem_rdata_i,
  output logic [N_TGT-1:0]       tgt_req,
  input  logic [N_TGT-1:0]       tgt_gnt,
  output logic [31:0]            tgt_addr,
  output logic                   tgt_we,
  output logic [MEM_W/8-1:0]     tgt_be,
  output logic [MEM_W-1:0]       tgt_wdata,
  input  logic [N_TGT-1:0]       tgt_rvalid,
  input  logic [N_TGT*MEM_W-1:0] tgt_rdata,
  output logic                   proto_err
);

  localparam int unsigned IDW   = $clog2(N_TGT + 1);
  localparam int unsigned ENT_W = IDW + 1;
  localparam logic [IDW-1:0] ERR_SEL = IDW'(N_TGT);

  region_t        cur_region;
  logic           hit;
  logic [IDW-1:0] sel;
  logic [31:0]    sel_base;

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [ENT_W-1:0] head;
  logic [IDW-1:0]   head_id;
  logic             head_we;
  logic             head_err;
  logic             head_rvalid;
  logic [MEM_W-1:0] head_rdata;
  logic             stray_rsp;

  // Address decode: scanning downwards lets the lowest matching index win.
  always_comb begin
    cur_region = '0;
    hit        = 1'b0;
    sel        = ERR_SEL;
    sel_base   = '0;
    for (int i = int'(N_TGT) - 1; i >= 0; i--) begin
      cur_region.base  = REGION_BASE[i*32 +: 32];
      cur_region.limit = REGION_LIMIT[i*32 +: 32];
      if (in_region(cur_region, vproc_mem_addr_o)) begin
        hit      = 1'b1;
        sel      = IDW'(i);
        sel_base = cur_region.base;
      end
    end
  end

  // Request mux; unmapped requests are accepted locally without a target.
  always_comb begin
    tgt_req         = '0;
    vproc_mem_gnt_i = 1'b0;
    if (vproc_mem_req_o && !fifo_full) begin
      if (hit) begin
        for (int i = 0; i < int'(N_TGT); i++) begin
          if (sel == IDW'(i)) begin
            tgt_req[i]      = 1'b1;
            vproc_mem_gnt_i = tgt_gnt[i];
          end
        end
      end else begin
        vproc_mem_gnt_i = 1'b1;
      end
    end
  end

  assign tgt_addr  = vproc_mem_addr_o - sel_base;
  assign tgt_we    = vproc_mem_we_o;
  assign tgt_be    = vproc_mem_be_o;
  assign tgt_wdata = vproc_mem_wdata_o;

  router_id_fifo #(
    .W     (ENT_W),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vproc_mem_gnt_i),
    .push_data ({vproc_mem_we_o, sel}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign head_we  = head[ENT_W-1];
  assign head_id  = head[IDW-1:0];
  assign head_err = (head_id == ERR_SEL);

  // Only the head target may respond; anything else is a protocol violation.
  always_comb begin
    head_rvalid = 1'b0;
    head_rdata  = '0;
    stray_rsp   = 1'b0;
    for (int i = 0; i < int'(N_TGT); i++) begin
      if (!fifo_empty && head_id == IDW'(i)) begin
        head_rvalid = tgt_rvalid[i];
        head_rdata  = tgt_rdata[i*MEM_W +: MEM_W];
      end else if (tgt_rvalid[i]) begin
        stray_rsp = 1'b1;
      end
    end
  end

  assign pop = !fifo_empty && (head_err || head_rvalid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vproc_mem_rvalid_i <= 1'b0;
      vproc_mem_err_i    <= 1'b0;
      vproc_mem_rdata_i  <= '0;
      proto_err          <= 1'b0;
    end else begin
      vproc_mem_rvalid_i <= pop;
      vproc_mem_err_i    <= pop && head_err;
      vproc_mem_rdata_i  <= (pop && !head_err && !head_we) ? head_rdata : '0;
      if (stray_rsp) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_region_router.sv
// Randomised scoreboard bench for mem_region_router with a behavioural memory map and targets.
module tb_mem_region_router;

  localparam int unsigned MW = 32;
  localparam int unsigned NT = 3;
  localparam int unsigned MO = 4;

  // Memory map as a plain table: GPIO, timer, storage.
  localparam logic [31:0] BASES  [NT] = '{32'h0000_0101, 32'h0000_010B, 32'h0000_1000};
  localparam logic [31:0] LIMITS [NT] = '{32'h0000_010A, 32'h0000_010B, 32'hFFFF_FFFF};

  logic              clk = 1'b0;
  logic              rst;
  logic              req, gnt, we, rvalid, err, proto_err, t_we;
  logic [31:0]       addr, wdata, rdata, t_addr, t_wdata;
  logic [3:0]        be, t_be;
  logic [NT-1:0]     t_req, t_gnt, t_rvalid;
  logic [NT*MW-1:0]  t_rdata;

  mem_region_router dut (
    .clk(clk), .rst(rst),
    .vproc_mem_req_o(req), .vproc_mem_gnt_i(gnt), .vproc_mem_addr_o(addr),
    .vproc_mem_we_o(we), .vproc_mem_be_o(be), .vproc_mem_wdata_o(wdata),
    .vproc_mem_rvalid_i(rvalid), .vproc_mem_err_i(err), .vproc_mem_rdata_i(rdata),
    .tgt_req(t_req), .tgt_gnt(t_gnt), .tgt_addr(t_addr), .tgt_we(t_we),
    .tgt_be(t_be), .tgt_wdata(t_wdata), .tgt_rvalid(t_rvalid), .tgt_rdata(t_rdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; logic [31:0] rdata; int lat; } stim_t;
  typedef struct { int tgt; int lat; logic [31:0] rdata; } out_t;
  typedef struct { logic err; logic [31:0] rdata; } exp_t;

  stim_t stim_q[$];
  out_t  out_q[$];
  exp_t  sb_q[$];
  stim_t cur;
  bit    cur_valid, acc_flag, pop_flag, hold_rsp;
  int    tests, fails;

  function automatic int ref_target(input logic [31:0] a);
    for (int i = 0; i < int'(NT); i++)
      if (a >= BASES[i] && a <= LIMITS[i]) return i;
    return int'(NT);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic [31:0] a, input logic w, input logic [31:0] rd, input int lat);
    stim_t s;
    s.addr = a; s.we = w; s.be = 4'($urandom); s.wdata = $urandom; s.rdata = rd; s.lat = lat;
    return s;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0: begin a = $urandom; if (a < 32'h1000) a = a + 32'h1000; end
      1: a = 32'h0000_010B;
      2: a = 32'h0000_0101 + 32'($urandom_range(0, 9));
      3: a = 32'($urandom_range(0, 32'h100));
      default: a = 32'h0000_010C + 32'($urandom_range(0, 32'hEF3));
    endcase
    return a;
  endfunction

  // One clock of the core driver and the in-order target model.
  task automatic step();
    @(posedge clk);
    #1;
    t_rvalid = '0;
    t_rdata  = {$urandom, $urandom, $urandom};
    if (pop_flag) begin void'(out_q.pop_front()); pop_flag = 0; end
    if (acc_flag) begin
      out_q.push_back('{ref_target(cur.addr), cur.lat, cur.rdata});
      cur_valid = 0; acc_flag = 0;
    end
    if (out_q.size() > 0) begin
      if (out_q[0].tgt == int'(NT)) pop_flag = 1;
      else if (!hold_rsp) begin
        if (out_q[0].lat == 0) begin
          t_rvalid[out_q[0].tgt] = 1'b1;
          t_rdata[out_q[0].tgt*MW +: MW] = out_q[0].rdata;
          pop_flag = 1;
        end else out_q[0].lat = out_q[0].lat - 1;
      end
    end
    if (!cur_valid && stim_q.size() > 0) begin cur = stim_q.pop_front(); cur_valid = 1; end
    req = cur_valid; addr = cur.addr; we = cur.we; be = cur.be; wdata = cur.wdata;
    for (int i = 0; i < int'(NT); i++) t_gnt[i] = ($urandom_range(0, 9) < 7);
  endtask

  task automatic drain();
    int k = 0;
    while ((cur_valid || stim_q.size() > 0 || out_q.size() > 0 || sb_q.size() > 0) && k < 3000) begin
      step(); k++;
    end
    check("drain_done", 64'(k >= 3000), 64'(0));
  endtask

  task automatic check_reset_outputs();
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_tgt_req", 64'(t_req), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_proto_err", 64'(proto_err), 64'(0));
  endtask

  // Monitor: handshake checks and in-order response scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid) begin
        if (sb_q.size() == 0) check("spurious_rsp", 64'(1), 64'(0));
        else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rsp_err", 64'(err), 64'(e.err));
          check("rsp_rdata", 64'(rdata), 64'(e.rdata));
        end
      end
      if (req) begin
        int t;
        bit full;
        logic [NT-1:0] ereq;
        t = ref_target(addr);
        full = (out_q.size() == int'(MO));
        ereq = '0;
        if (!full && t < int'(NT)) ereq[t] = 1'b1;
        check("gnt", 64'(gnt), 64'(full ? 1'b0 : (t == int'(NT) ? 1'b1 : t_gnt[t])));
        check("tgt_req", 64'(t_req), 64'(ereq));
        if (t < int'(NT)) begin
          check("tgt_addr", 64'(t_addr), 64'(addr - BASES[t]));
          check("tgt_bcast", {t_we, t_be, t_wdata}, {we, be, wdata});
        end
        if (gnt) begin
          acc_flag = 1;
          sb_q.push_back('{t == int'(NT), (t == int'(NT) || we) ? 32'h0 : cur.rdata});
        end
      end
    end
  end

  initial begin
    int k;
    tests = 0; fails = 0;
    rst = 1; req = 0; addr = '0; we = 0; be = '0; wdata = '0;
    t_gnt = '0; t_rvalid = '0; t_rdata = '0;
    cur_valid = 0; acc_flag = 0; pop_flag = 0; hold_rsp = 0;
    cur = mk(32'h0, 1'b0, 32'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst = 0;

    // Directed map corners, error path and out-of-order-latency ordering.
    stim_q.push_back(mk(32'h0000_1010, 1'b0, 32'hDEAD_BEEF, 2));
    stim_q.push_back(mk(32'h0000_0050, 1'b1, 32'h1234_5678, 0));
    stim_q.push_back(mk(32'h0000_1000, 1'b0, 32'h1111_1111, 4));
    stim_q.push_back(mk(32'h0000_010B, 1'b0, 32'h2222_2222, 0));
    stim_q.push_back(mk(32'h0000_0101, 1'b1, 32'h3333_3333, 1));
    stim_q.push_back(mk(32'h0000_010A, 1'b0, 32'h4444_4444, 0));
    stim_q.push_back(mk(32'h0000_0100, 1'b0, 32'h5555_5555, 0));
    stim_q.push_back(mk(32'h0000_010C, 1'b0, 32'h6666_6666, 0));
    stim_q.push_back(mk(32'h0000_0FFF, 1'b0, 32'h7777_7777, 0));
    stim_q.push_back(mk(32'hFFFF_FFFF, 1'b0, 32'h8888_8888, 3));
    drain();

    // Fill the ID FIFO with responses held off; the fifth request must stall.
    hold_rsp = 1;
    for (int i = 0; i < 5; i++) stim_q.push_back(mk(32'h0000_2000 + 32'(i*4), 1'b0, $urandom, 0));
    repeat (15) step();
    check("fifo_fill", 64'(out_q.size()), 64'(MO));
    check("fifth_held", 64'(cur_valid), 64'(1));
    hold_rsp = 0;
    drain();

    for (int i = 0; i < 200; i++)
      stim_q.push_back(mk(rand_addr(), 1'($urandom), $urandom, $urandom_range(0, 3)));
    drain();
    @(negedge clk);
    check("proto_err_clean", 64'(proto_err), 64'(0));

    // A timer response while storage is at the head is ignored and flagged.
    hold_rsp = 1;
    stim_q.push_back(mk(32'h0000_1000, 1'b0, 32'hCAFE_0001, 0));
    k = 0;
    while (!(out_q.size() == 1 && !cur_valid) && k < 100) begin step(); k++; end
    check("issue_timeout", 64'(k >= 100), 64'(0));
    t_rvalid[1] = 1'b1;
    t_rdata[1*MW +: MW] = 32'h0BAD_0BAD;
    step();
    @(negedge clk);
    check("proto_err_set", 64'(proto_err), 64'(1));
    check("stray_ignored", 64'(rvalid), 64'(0));
    hold_rsp = 0;
    drain();
    @(negedge clk);
    check("proto_err_sticky", 64'(proto_err), 64'(1));

    // Reset with three transactions in flight, then resume traffic.
    hold_rsp = 1;
    for (int i = 0; i < 3; i++) stim_q.push_back(mk(32'h0000_3000 + 32'(i), 1'b0, $urandom, 0));
    k = 0;
    while (!(out_q.size() == 3 && !cur_valid) && k < 100) begin step(); k++; end
    check("fill3_timeout", 64'(k >= 100), 64'(0));
    rst = 1; req = 0; t_rvalid = '0;
    out_q.delete(); sb_q.delete(); stim_q.delete();
    cur_valid = 0; acc_flag = 0; pop_flag = 0; hold_rsp = 0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 30; i++)
      stim_q.push_back(mk(rand_addr(), 1'($urandom), $urandom, $urandom_range(0, 3)));
    drain();
    @(negedge clk);
    check("proto_err_after_rst", 64'(proto_err), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
